// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (icache/dcache) arbiter onto a single RAM with starvation guard
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ramerr
);

    localparam int CW_MIN = $clog2(STARVE_LIMIT + 1);
    localparam int CW     = (CW_MIN > 3) ? CW_MIN : 3;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;

    logic ireq;
    logic dreq;
    logic i_done;
    logic d_done;

    assign ireq   = iREN;
    assign dreq   = dREN | dWEN;
    // A completion only counts while the owner still holds its request.
    assign i_done = (state == IGNT) && ireq && (ramstate == RAM_ACCESS);
    assign d_done = (state == DGNT) && dreq && (ramstate == RAM_ACCESS);

    // Grant sequencing, starvation counter and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            ramerr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ireq) begin
                        starve_cnt <= '0;
                    end
                    if (dreq && !(ireq && (starve_cnt == LIMIT))) begin
                        state <= DGNT;
                    end else if (ireq) begin
                        state <= IGNT;
                    end
                end
                IGNT: begin
                    if (!ireq) begin
                        state <= IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        ramerr <= 1'b1;
                    end else if (i_done) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end
                end
                DGNT: begin
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        ramerr <= 1'b1;
                    end else if (d_done) begin
                        state <= IDLE;
                        if (ireq && (starve_cnt != LIMIT)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM strobes and cache responses follow the owner's live inputs so completion is same-cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        case (state)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~i_done;
                iload   = i_done ? ramload : 32'd0;
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~d_done;
                dload    = d_done ? ramload : 32'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with directed scenarios and a random model run
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ramerr;

    int errors;
    int checks;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        ramstate = 2'd0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        // requests present while reset is held must not leak through
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1; ramstate = 2'd2;
        iaddr = 32'h1111_0000; daddr = 32'h2222_0000; dstore = 32'h3333_0000;
        ramload = 32'hDEAD_BEEF;
        step();
        @(negedge CLK);
        checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'd0) begin
            errors++;
            $display("FAIL reset_ram_side got REN=%0b WEN=%0b addr=%h store=%h want all 0",
                     ramREN, ramWEN, ramaddr, ramstore);
        end
        checks++;
        if ({iwait, dwait, iload, dload, ramerr} !== {1'b1, 1'b1, 64'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_cache_side got iwait=%0b dwait=%0b iload=%h dload=%h ramerr=%0b want 1 1 0 0 0",
                     iwait, dwait, iload, dload, ramerr);
        end
        RST = 1'b0;
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_lone_fetch();
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd0;
        @(negedge CLK);
        checks++;
        if (iwait !== 1'b1 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL fetch_cycle1 got iwait=%0b ramREN=%0b want 1 0", iwait, ramREN);
        end
        step();
        ramstate = 2'd2; ramload = 32'h2402_000A;
        @(negedge CLK);
        checks++;
        if (iwait !== 1'b0 || iload !== 32'h2402_000A) begin
            errors++;
            $display("FAIL fetch_cycle2 got iwait=%0b iload=%h want 0 2402000a", iwait, iload);
        end
        checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || dwait !== 1'b1 || dload !== 32'd0) begin
            errors++;
            $display("FAIL fetch_ram got REN=%0b WEN=%0b addr=%h dwait=%0b dload=%h want 1 0 40 1 0",
                     ramREN, ramWEN, ramaddr, dwait, dload);
        end
        step();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (iwait !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'd0) begin
            errors++;
            $display("FAIL fetch_back_idle got iwait=%0b ramREN=%0b addr=%h want 1 0 0", iwait, ramREN, ramaddr);
        end
        step();
    endtask

    task automatic test_simultaneous();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h80;
        ramstate = 2'd0;
        step();
        ramstate = 2'd2; ramload = 32'h1234_5678;
        @(negedge CLK);
        checks++;
        if (dwait !== 1'b0 || dload !== 32'h1234_5678 || ramaddr !== 32'h80 || ramREN !== 1'b1 || ramWEN !== 1'b0) begin
            errors++;
            $display("FAIL simul_dcache_first got dwait=%0b dload=%h addr=%h REN=%0b WEN=%0b want 0 12345678 80 1 0",
                     dwait, dload, ramaddr, ramREN, ramWEN);
        end
        checks++;
        if (iwait !== 1'b1 || iload !== 32'd0) begin
            errors++;
            $display("FAIL simul_icache_held got iwait=%0b iload=%h want 1 0", iwait, iload);
        end
        step();
        dREN = 1'b0; ramstate = 2'd0;
        step();
        ramstate = 2'd2; ramload = 32'hCAFE_F00D;
        @(negedge CLK);
        checks++;
        if (iwait !== 1'b0 || iload !== 32'hCAFE_F00D || ramaddr !== 32'h44) begin
            errors++;
            $display("FAIL simul_icache_after got iwait=%0b iload=%h addr=%h want 0 cafef00d 44",
                     iwait, iload, ramaddr);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_starvation();
        int  stores;
        bit  got_i;
        iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; dREN = 1'b0;
        daddr = 32'h200; dstore = 32'h55AA_55AA; ramstate = 2'd2; ramload = 32'h0BAD_F00D;
        stores = 0;
        got_i  = 1'b0;
        for (int c = 0; c < 40 && !got_i; c++) begin
            @(negedge CLK);
            if (ramWEN === 1'b1 && dwait === 1'b0) stores++;
            if (ramREN === 1'b1 && iwait === 1'b0) begin
                got_i = 1'b1;
                checks++;
                if (dut.starve_cnt !== 3'(LIMIT)) begin
                    errors++;
                    $display("FAIL starve_cnt_at_limit got %0d want %0d", dut.starve_cnt, LIMIT);
                end
                dWEN = 1'b0;
            end
            step();
        end
        checks++;
        if (!got_i) begin
            errors++;
            $display("FAIL starve_icache_grant got none within 40 cycles want one");
        end
        checks++;
        if (stores !== LIMIT) begin
            errors++;
            $display("FAIL starve_store_count got %0d want %0d", stores, LIMIT);
        end
        @(negedge CLK);
        checks++;
        if (dut.starve_cnt !== '0) begin
            errors++;
            $display("FAIL starve_cnt_cleared got %0d want 0", dut.starve_cnt);
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_error();
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h300; ramstate = 2'd0;
        step();
        ramstate = 2'd3;
        @(negedge CLK);
        checks++;
        if (dwait !== 1'b1 || ramREN !== 1'b1) begin
            errors++;
            $display("FAIL err_first got dwait=%0b ramREN=%0b want 1 1", dwait, ramREN);
        end
        step();
        @(negedge CLK);
        checks++;
        if (ramerr !== 1'b1 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL err_second got ramerr=%0b dwait=%0b want 1 1", ramerr, dwait);
        end
        step();
        ramstate = 2'd2; ramload = 32'h7777_0001;
        @(negedge CLK);
        checks++;
        if (dwait !== 1'b0 || dload !== 32'h7777_0001 || ramerr !== 1'b1) begin
            errors++;
            $display("FAIL err_access got dwait=%0b dload=%h ramerr=%0b want 0 77770001 1", dwait, dload, ramerr);
        end
        step();
        idle_inputs();
        step();
        @(negedge CLK);
        checks++;
        if (ramerr !== 1'b1 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got ramerr=%0b dwait=%0b want 1 1", ramerr, dwait);
        end
        step();
    endtask

    task automatic test_abort();
        iREN = 1'b1; iaddr = 32'h500; ramstate = 2'd1;
        step();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy got ramREN=%0b iwait=%0b want 1 1", ramREN, iwait);
        end
        step();
        iREN = 1'b0;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_drop got ramREN=%0b iwait=%0b want 0 1", ramREN, iwait);
        end
        step();
        // back in IDLE: a fresh request with ACCESS must still wait a cycle
        iREN = 1'b1; ramstate = 2'd2; ramload = 32'h9999_0000;
        @(negedge CLK);
        checks++;
        if (iwait !== 1'b1 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got iwait=%0b ramREN=%0b want 1 0", iwait, ramREN);
        end
        step();
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        dWEN = 1'b1; dREN = 1'b0; daddr = 32'h600; dstore = 32'h1357_9BDF; ramstate = 2'd1;
        step();
        @(negedge CLK);
        checks++;
        if (ramWEN !== 1'b1 || ramerr !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant got ramWEN=%0b ramerr=%0b want 1 1", ramWEN, ramerr);
        end
        RST = 1'b1;
        step();
        ramstate = 2'd2;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'd0 || ramstore !== 32'd0 || ramerr !== 1'b0 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle got REN=%0b WEN=%0b addr=%h store=%h ramerr=%0b dwait=%0b want 0 0 0 0 0 1",
                     ramREN, ramWEN, ramaddr, ramstore, ramerr, dwait);
        end
        RST = 1'b0;
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_random();
        int          owner;   // 0 nobody, 1 icache, 2 dcache
        int          cnt;
        bit          err;
        bit          ir, dr, live, done;
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        RST = 1'b1;
        step();
        RST = 1'b0;
        owner = 0; cnt = 0; err = 1'b0;
        for (int c = 0; c < 600; c++) begin
            RST      = ($urandom_range(0, 59) == 0);
            iREN     = ($urandom_range(0, 3) != 0);
            dREN     = ($urandom_range(0, 2) == 0);
            dWEN     = ($urandom_range(0, 2) == 0);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            @(negedge CLK);
            ir   = iREN;
            dr   = dREN || dWEN;
            live = (owner == 1) ? ir : (owner == 2) ? dr : 1'b0;
            done = live && (ramstate == 2'd2);
            e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'd0; e_store = 32'd0;
            e_iw = 1'b1; e_dw = 1'b1; e_il = 32'd0; e_dl = 32'd0;
            if (owner == 1) begin
                e_ren = ir; e_addr = iaddr;
                e_iw = !done; e_il = done ? ramload : 32'd0;
            end else if (owner == 2) begin
                e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
                e_dw = !done; e_dl = done ? ramload : 32'd0;
            end
            checks++;
            if (ramREN !== e_ren || ramWEN !== e_wen) begin
                errors++;
                $display("FAIL rnd_strobes cyc=%0d got REN=%0b WEN=%0b want %0b %0b", c, ramREN, ramWEN, e_ren, e_wen);
            end
            checks++;
            if (ramaddr !== e_addr || ramstore !== e_store) begin
                errors++;
                $display("FAIL rnd_addr_data cyc=%0d got addr=%h store=%h want %h %h", c, ramaddr, ramstore, e_addr, e_store);
            end
            checks++;
            if (iwait !== e_iw || iload !== e_il) begin
                errors++;
                $display("FAIL rnd_icache cyc=%0d got iwait=%0b iload=%h want %0b %h", c, iwait, iload, e_iw, e_il);
            end
            checks++;
            if (dwait !== e_dw || dload !== e_dl) begin
                errors++;
                $display("FAIL rnd_dcache cyc=%0d got dwait=%0b dload=%h want %0b %h", c, dwait, dload, e_dw, e_dl);
            end
            checks++;
            if (ramerr !== err) begin
                errors++;
                $display("FAIL rnd_ramerr cyc=%0d got %0b want %0b", c, ramerr, err);
            end
            // advance the reference to the state after this clock edge
            if (RST) begin
                owner = 0; cnt = 0; err = 1'b0;
            end else if (owner == 0) begin
                if (!ir) cnt = 0;
                if (dr && !(ir && cnt == LIMIT)) owner = 2;
                else if (ir) owner = 1;
            end else if (!live) begin
                owner = 0;
            end else if (ramstate == 2'd3) begin
                err = 1'b1;
            end else if (done) begin
                if (owner == 1) cnt = 0;
                else if (ir && cnt < LIMIT) cnt = cnt + 1;
                owner = 0;
            end
            step();
        end
        RST = 1'b0;
        idle_inputs();
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RST = 1'b1;
        iREN = 1'b0; iaddr = 32'd0; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = 2'd0;
        step();
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_error();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive dcache grants allowed while an icache request is pending.
REQ-002 SHALL have ports, clock and reset first: CLK in 1, clock; RST in 1, reset.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 SHALL have icache-side ports: iREN in 1, fetch request; iaddr in 32, word address; iwait out 1, stall; iload out 32, fetched word.
REQ-005 SHALL have dcache-side ports: dREN in 1, load request; dWEN in 1, store request; daddr in 32; dstore in 32, store data; dwait out 1, stall; dload out 32, loaded word.
REQ-006 SHALL have RAM-side ports: ramREN out 1; ramWEN out 1; ramaddr out 32; ramstore out 32; ramload in 32; ramstate in 2, where FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-007 SHALL have port ramerr out 1: sticky flag for RAM error.

Function
REQ-008 SHALL implement FSM states IDLE, IGNT (icache owns RAM) and DGNT (dcache owns RAM), with the state held in a register.
REQ-009 IDLE SHALL drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
REQ-010 In IDLE with dREN|dWEN=1, the FSM SHALL go to DGNT next cycle, unless REQ-012 applies.
REQ-011 In IDLE with only iREN=1, the FSM SHALL go to IGNT next cycle.
REQ-012 In IDLE with both sides requesting and starve counter == STARVE_LIMIT, the FSM SHALL go to IGNT.
REQ-013 Starve counter SHALL be 3 bits minimum, saturating at STARVE_LIMIT.
REQ-014 Starve counter SHALL increment on each DGNT completion while iREN=1.
REQ-015 Starve counter SHALL clear on each IGNT completion, and whenever iREN=0 in IDLE.
REQ-016 In IGNT, outputs SHALL be: ramREN=1, ramaddr=iaddr, ramWEN=0.
REQ-017 In DGNT, outputs SHALL be: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. dWEN&dREN together SHALL be treated as a store.
REQ-018 Completion SHALL be ramstate==ACCESS while in a grant state; in that same cycle the owner's wait SHALL be 0 and the owner's load SHALL equal ramload, combinationally.
REQ-019 After completion the FSM SHALL return to IDLE next cycle; minimum access latency is 2 cycles, request to wait=0.
REQ-020 ramstate FREE or BUSY in a grant state SHALL keep the FSM in that state with the owner's wait=1.
REQ-021 ramstate ERROR in a grant state SHALL set ramerr=1, keep the FSM in that state with wait=1, and retry the access.
REQ-022 ramerr SHALL clear only on reset.
REQ-023 If the owner drops its request in a grant state, the FSM SHALL abort to IDLE next cycle. RAM strobes SHALL follow the dropped request that same cycle, and no completion is signalled.
REQ-024 The non-owner's wait SHALL be 1 and its load SHALL be 0 at all times.
REQ-025 Owner address or data changes during a grant SHALL pass through to RAM; no latching.

Reset
REQ-026 RST=1 at a CLK edge SHALL force IDLE, starve counter=0 and ramerr=0.
REQ-027 All outputs SHALL take the IDLE values of REQ-009 from the cycle after reset.
REQ-028 Reset asserted mid-grant SHALL abort the transaction with no completion signalled.

Verification
REQ-029 Bench SHALL cover a lone fetch: iREN=1, iaddr=0x40, RAM returns ACCESS on the first grant cycle with ramload=0x2402000A -> iwait=0 and iload=0x2402000A in cycle 2, then IDLE.
REQ-030 Bench SHALL cover a simultaneous request: iREN=1, dREN=1, daddr=0x80 -> DGNT first, dload valid; icache served after.
REQ-031 Bench SHALL cover starvation: iREN held, dWEN reasserted continuously, STARVE_LIMIT=4 -> exactly 4 dcache stores, then an icache grant, and the counter reads 0.
REQ-032 Bench SHALL cover an error: ramstate=ERROR for 2 cycles then ACCESS in DGNT -> ramerr=1 stays high, dwait=0 only on the ACCESS cycle.
REQ-033 Bench SHALL cover an abort: iREN dropped in IGNT with ramstate=BUSY -> ramREN=0 that cycle, IDLE next, iwait stays 1.
REQ-034 Bench SHALL cover reset mid-access: RST=1 during DGNT -> IDLE, ramerr=0, all RAM strobes 0 next cycle.
